// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase timer: phase encoding,
// one-hot light codes, default phase durations and small phase helpers.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } phase_t;

    localparam logic [2:0] LIGHT_GREEN  = 3'd1;
    localparam logic [2:0] LIGHT_YELLOW = 3'd2;
    localparam logic [2:0] LIGHT_RED    = 3'd4;

    localparam int unsigned DEF_TICK_DIV    = 10;
    localparam int unsigned DEF_GREEN_TIME  = 5;
    localparam int unsigned DEF_YELLOW_TIME = 2;
    localparam int unsigned DEF_RED_TIME    = 4;

    // Light code the FSM is expected to show in a given phase. The unused
    // encoding maps to zero so it can never match a legal lightIn.
    function automatic logic [2:0] onehot(input phase_t p);
        case (p)
            GREEN:   return LIGHT_GREEN;
            YELLOW:  return LIGHT_YELLOW;
            RED:     return LIGHT_RED;
            default: return 3'd0;
        endcase
    endfunction

    // Phase sequence G -> Y -> R -> G.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            default: return GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and emits a registered
// one-cycle tick in the cycle after the counter holds its last value.
module tick_prescaler
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Wrap the counter at LAST and flag the wrap for the following cycle.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase countdown generator for the traffic-light FSM. Tracks the FSM phase
// internally, reloads the per-phase duration on the same edge the FSM
// changes state, flags any disagreement with the FSM's lightOut, and lets a
// pedestrian request cut the red phase short.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned GREEN_TIME  = DEF_GREEN_TIME,
    parameter int unsigned YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int unsigned RED_TIME    = DEF_RED_TIME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstType,
    input  logic [2:0] lightIn,
    input  logic       pedReq,
    output logic [2:0] count,
    output logic       tick,
    output logic       pedWait,
    output logic       phaseErr
);

    localparam logic [2:0] GREEN_RL  = 3'(GREEN_TIME);
    localparam logic [2:0] YELLOW_RL = 3'(YELLOW_TIME);
    localparam logic [2:0] RED_RL    = 3'(RED_TIME);

    function automatic logic [2:0] reload(input phase_t p);
        case (p)
            GREEN:   return GREEN_RL;
            YELLOW:  return YELLOW_RL;
            default: return RED_RL;
        endcase
    endfunction

    phase_t     phase_q, phase_d;
    logic [2:0] count_q, count_d;
    logic       ped_wait_q, ped_wait_d;
    logic       phase_err_q, phase_err_d;
    logic       ped_sync1_q, ped_sync2_q, ped_prev_q;
    logic       tick_w;
    logic       term;
    logic       ped_rise;
    logic       light_valid;
    phase_t     light_phase;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    // Decode the FSM light into a phase; anything not one-hot is invalid.
    always_comb begin
        light_valid = 1'b1;
        light_phase = GREEN;
        case (lightIn)
            LIGHT_GREEN:  light_phase = GREEN;
            LIGHT_YELLOW: light_phase = YELLOW;
            LIGHT_RED:    light_phase = RED;
            default:      light_valid = 1'b0;
        endcase
    end

    // Terminal count (the FSM moves on this value) and synchronised ped edge.
    always_comb begin
        term     = ((phase_q == GREEN) && (count_q == 3'd2)) ||
                   ((phase_q != GREEN) && (count_q == 3'd1));
        ped_rise = ped_sync2_q & ~ped_prev_q;
    end

    // Next phase/count: resync on mismatch, then phase change, then ped
    // shortening of red, then ordinary countdown. A tick arriving together
    // with a higher-priority event is dropped, so count never underflows.
    always_comb begin
        phase_d     = phase_q;
        count_d     = count_q;
        ped_wait_d  = ped_wait_q;
        phase_err_d = phase_err_q;
        if (lightIn != onehot(phase_q)) begin
            phase_err_d = 1'b1;
            if (light_valid) begin
                phase_d = light_phase;
                count_d = reload(light_phase);
            end
        end else if (term) begin
            phase_d = next_phase(phase_q);
            count_d = reload(phase_d);
            if (phase_d == GREEN) begin
                ped_wait_d = 1'b0;
            end
        end else if (tick_w && (phase_q == RED) && ped_wait_q && (count_q > 3'd2)) begin
            count_d = 3'd2;
        end else if (tick_w) begin
            count_d = count_q - 3'd1;
        end
        // A new request beats the clear on green entry.
        if (ped_rise) begin
            ped_wait_d = 1'b1;
        end
    end

    // Phase/count state and status flags; reset phase follows rstType.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= rstType ? GREEN : RED;
            count_q     <= rstType ? GREEN_RL : RED_RL;
            ped_wait_q  <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            count_q     <= count_d;
            ped_wait_q  <= ped_wait_d;
            phase_err_q <= phase_err_d;
        end
    end

    // Two-flop synchroniser for the button plus a delay flop for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_sync1_q <= 1'b0;
            ped_sync2_q <= 1'b0;
            ped_prev_q  <= 1'b0;
        end else begin
            ped_sync1_q <= pedReq;
            ped_sync2_q <= ped_sync1_q;
            ped_prev_q  <= ped_sync2_q;
        end
    end

    assign count    = count_q;
    assign tick     = tick_w;
    assign pedWait  = ped_wait_q;
    assign phaseErr = phase_err_q;

endmodule
